// File: rtl/rec_stream_mux.sv
// -----------------------------------------------------------------------------
// rec_stream_mux_ch : one recording-channel FIFO with level and drop counter.
//   wr_i/din_i   write strobe and word from the neural-interface channel
//   rd_i         pop the head word (only asserted for the granted channel)
//   clr_i        synchronous clear of the drop counter
//   full_o       level == DEPTH
//   level_o      occupancy 0..DEPTH
//   drop_o       saturating count of writes lost because the FIFO was full
//   head_o       word at the read pointer
//
// rec_stream_mux : N-channel recording stream multiplexer. Round-robin drains
// the per-channel FIFOs as framed packets (header + up to BURST data words)
// onto one valid/ready stream.
//   CLK, RESETn         clock, asynchronous active-low reset
//   enable              permits new packets to start
//   ch_wr, ch_din       per-channel write strobe / data (channel k at [k*DW +: DW])
//   ch_full, ch_level   per-channel full flag and occupancy
//   ch_drop, drop_clr   per-channel saturating drop counters and their clear
//   out_valid/out_data/out_ready  output stream
//   busy                packet in progress
// -----------------------------------------------------------------------------
module rec_stream_mux_ch #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          wr_i,
  input  logic [DW-1:0] din_i,
  input  logic          rd_i,
  input  logic          clr_i,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic [15:0]   drop_o,
  output logic [DW-1:0] head_o
);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [15:0]   drop_q;
  logic          full, push, lost;

  assign full = (level_q == LW'(DEPTH));
  // Full is judged on the pre-edge level, so a pop in the same cycle frees the
  // slot the write lands in (wptr == rptr when full).
  assign push = wr_i & (~full | rd_i);
  assign lost = wr_i & full & ~rd_i;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (rd_i) rptr_q <= rptr_q + 1'b1;
      case ({push, rd_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
      if (clr_i)                           drop_q <= '0;
      else if (lost && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign full_o  = full;
  assign level_o = level_q;
  assign drop_o  = drop_q;
  assign head_o  = mem_q[rptr_q];
endmodule

module rec_stream_mux #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int BURST = 8
) (
  input  logic                               CLK,
  input  logic                               RESETn,
  input  logic                               enable,
  input  logic [NCH-1:0]                     ch_wr,
  input  logic [NCH*DW-1:0]                  ch_din,
  output logic [NCH-1:0]                     ch_full,
  output logic [NCH*($clog2(DEPTH)+1)-1:0]   ch_level,
  output logic [NCH*16-1:0]                  ch_drop,
  input  logic                               drop_clr,
  output logic                               out_valid,
  output logic [DW-1:0]                      out_data,
  input  logic                               out_ready,
  output logic                               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_e;

  state_e                   state_q;
  logic [CW-1:0]            g_q, rr_q, gsel;
  logic [LW-1:0]            cnt_q, nsel;
  logic [DW-1:0]            hdr_q, hdr_d;
  logic                     ov_q, busy_q, any_ne;
  logic [NCH-1:0]           pop;
  logic [NCH-1:0][LW-1:0]   lvl;
  logic [NCH-1:0][DW-1:0]   head;

  // Only the granted channel is ever popped, one word per accepted data beat.
  assign pop = (state_q == S_DATA && out_ready) ? (NCH'(1) << g_q) : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    rec_stream_mux_ch #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ch (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .wr_i    (ch_wr[k]),
      .din_i   (ch_din[k*DW +: DW]),
      .rd_i    (pop[k]),
      .clr_i   (drop_clr),
      .full_o  (ch_full[k]),
      .level_o (lvl[k]),
      .drop_o  (ch_drop[k*16 +: 16]),
      .head_o  (head[k])
    );
  end

  assign ch_level = lvl;

  // First non-empty channel at or after rr_q (mod NCH). Scanning downward
  // lets the smallest offset overwrite the others.
  always_comb begin
    int idx;
    idx    = 0;
    any_ne = 1'b0;
    gsel   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (lvl[CW'(idx)] != '0) begin
        any_ne = 1'b1;
        gsel   = CW'(idx);
      end
    end
  end

  always_comb begin
    nsel        = (lvl[gsel] > LW'(BURST)) ? LW'(BURST) : lvl[gsel];
    hdr_d       = '0;
    hdr_d[31:0] = {4'hA, 4'h0, 8'(gsel), 16'(nsel)};
  end

  // The packet length is fixed at grant time; later writes wait for the next one.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (enable && any_ne) begin
          g_q     <= gsel;
          cnt_q   <= nsel;
          hdr_q   <= hdr_d;
          rr_q    <= (gsel == CW'(NCH - 1)) ? '0 : gsel + 1'b1;
          state_q <= S_HDR;
          ov_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_HDR: if (out_ready) state_q <= S_DATA;
        S_DATA: if (out_ready) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            state_q <= S_IDLE;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data beats read FIFO storage directly; the head of the granted channel
  // cannot move until it is popped, so the word holds steady under stall.
  always_comb begin
    out_data = '0;
    if (state_q == S_HDR)       out_data = hdr_q;
    else if (state_q == S_DATA) out_data = head[g_q];
  end

  assign out_valid = ov_q;
  assign busy      = busy_q;
endmodule

// File: doc/rec_stream_mux.md
# rec_stream_mux

Parametrised N-channel recording stream multiplexer. It replaces the fixed one-FIFO-per-pipe recording path. Each neural-interface channel writes recording words into its own internal FIFO. A round-robin arbiter drains the channels as framed packets (one header word, then up to BURST data words) onto a single valid/ready output stream, which feeds one host pipe-out. Per-channel fill levels and saturating drop counters expose overflow to firmware.

## Interface
- NCH, 2: number of recording channels (1..16).
- DW, 32: word width (≥32).
- DEPTH, 16: per-channel FIFO depth (power of 2, ≥2); AW = log2(DEPTH).
- BURST, 8: maximum data words per packet (1..DEPTH).
- CLK  in  1  single clock for the whole block.
- RESETn  in  1  reset; asynchronous, active-low.
- enable  in  1  permits new packets to start.
- ch_wr  in  NCH  per-channel write strobe.
- ch_din  in  NCH*DW  per-channel write data; channel k occupies [k*DW +: DW].
- ch_full  out  NCH  channel FIFO full (level == DEPTH).
- ch_level  out  NCH*(AW+1)  per-channel occupancy, 0..DEPTH.
- ch_drop  out  NCH*16  per-channel saturating count of writes lost to full.
- drop_clr  in  1  synchronous clear of all drop counters.
- out_valid  out  1  output word valid.
- out_data  out  DW  output word.
- out_ready  in  1  consumer accepts word.
- busy  out  1  FSM not in IDLE.

## Operation
- Write side, per channel k:
  - ch_wr[k] & ~ch_full[k] stores ch_din word k at wptr, then wptr++ and level++.
  - ch_wr[k] & ch_full[k] discards the word and increments ch_drop[k], saturating at 16'hFFFF.
  - drop_clr has priority over an increment in the same cycle.
- FIFO pointers are AW bits and wrap modulo DEPTH. Level is held separately in AW+1 bits.
- Simultaneous write and read on the same channel: both take effect and level is unchanged. This holds even when full: the write is accepted, because full is evaluated before the read. Drops occur only when level == DEPTH and the channel is not being read that cycle.
- FSM states:
  - IDLE: if enable and any level > 0, grant g = first non-empty channel searching from rr_ptr upward (mod NCH). Latch n = min(level[g], BURST). Set hdr = {marker 4'hA, 4'h0, 8'(g), 16'(n)} in bits [31:0], upper bits 0. rr_ptr <= (g+1) mod NCH. Go to HEADER. Otherwise stay in IDLE.
  - HEADER: out_valid=1, out_data=hdr. On out_ready go to DATA with cnt=n.
  - DATA: out_valid=1, out_data=FIFO head of channel g. On out_ready pop channel g and cnt--. The last word (cnt==1) goes to IDLE.
- Words written to channel g after the grant are not included in the current packet.
- enable deasserted mid-packet: the current packet completes, then the FSM stays in IDLE.
- Only the granted channel is ever read.
- out_valid and out_data depend only on registered state and FIFO storage. There is no combinational path from out_ready to out_valid or out_data.
- Once out_valid is high, out_data is stable until accepted.

## Timing
- Reset (async assert, sync deassert expected externally): all pointers, levels, ch_drop and rr_ptr are 0. FSM is in IDLE. out_valid=0, out_data=0, busy=0, ch_full=0.
- Reset mid-packet aborts the packet; buffered data is lost.
- A word written at edge t is visible in ch_level after edge t and is eligible for grant in IDLE at the next edge.
- Packet cost with out_ready held high: 1 IDLE cycle + 1 header cycle + n data cycles. First write to header valid takes 2 cycles.
- out_ready low stalls in place with no loss.
- ch_full and ch_level are registered and update the cycle after the write or read edge.

## Test plan
- Single word: NCH=2. Write 32'h1234 to ch1 once, out_ready=1 -> header 32'hA0010001 then data 32'h1234. busy low after 3 cycles. ch_level[1] returns to 0.
- Burst split: write 11 words 1..11 to ch0, BURST=8 -> packet with header count 8 and words 1..8, then header count 3 and words 9..11, in order.
- Round-robin fairness: pre-fill ch0 and ch1 with 3 words each -> packets alternate ch0, ch1. With both refilled, rr_ptr grants ch0 next.
- Overflow: DEPTH=16, enable=0, write 20 words to ch0 -> ch_full[0]=1, ch_level=16, ch_drop[0]=4. drop_clr pulse -> 0. Write at full concurrent with a pop is accepted, not dropped.
- Backpressure: toggle out_ready pseudo-randomly over 200 words across 2 channels -> every word is delivered exactly once, in per-channel order. out_data is stable whenever out_valid=1 and out_ready=0.
- Reset mid-packet: assert RESETn=0 during DATA -> out_valid=0 immediately, all levels 0. After release, new writes produce fresh packets starting from ch0 priority.
